// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, load/store port, memory port and status.
// slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if;
  logic        f_req;
  logic [7:0]  f_addr;
  logic        f_ack;
  logic [19:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [7:0]  d_wdata;
  logic        d_ack;
  logic [19:0] d_rdata;
  logic        d_err;
  logic [7:0]  mem_addr;
  logic        mem_w;
  logic [7:0]  mem_in;
  logic [19:0] mem_out;
  logic        busy;
  logic        grant;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_out,
    output f_ack, f_rdata, d_ack, d_rdata, d_err, mem_addr, mem_w, mem_in, busy, grant
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_out,
    input  f_ack, f_rdata, d_ack, d_rdata, d_err, mem_addr, mem_w, mem_in, busy, grant
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/load-store arbiter and IDLE->ACCESS->DONE sequencer for the 20-bit program/data memory.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie break; default is data-over-fetch priority).
module mem_port_arbiter #(
  parameter int MEM_DEPTH = 201
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     bus
);

  localparam logic [8:0] DEPTH_LIM = 9'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  addr_r;
  logic [7:0]  wdata_r;
  logic        we_r;
  logic        range_err_r;
  logic        grant_r;
  logic [19:0] f_rdata_r;
  logic [19:0] d_rdata_r;
`ifdef MEM_ARB_RR_EN
  logic        last_grant_r;
`endif

  logic        pick_data_s;
  logic [7:0]  sel_addr_s;
  logic        sel_err_s;

  // Winner selection and the winner's address/range check.
  always_comb begin
    pick_data_s = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (bus.d_req && (!bus.f_req || !last_grant_r)) begin
      pick_data_s = 1'b1;
    end else begin
      pick_data_s = 1'b0;
    end
`else
    if (bus.d_req) begin
      pick_data_s = 1'b1;
    end else begin
      pick_data_s = 1'b0;
    end
`endif
    sel_addr_s = pick_data_s ? bus.d_addr : bus.f_addr;
    sel_err_s  = ({1'b0, sel_addr_s} >= DEPTH_LIM);
  end

  // Access sequencer: latch winner in IDLE, capture read data in ACCESS, ack in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= 8'h00;
      wdata_r      <= 8'h00;
      we_r         <= 1'b0;
      range_err_r  <= 1'b0;
      grant_r      <= 1'b0;
      f_rdata_r    <= 20'h00000;
      d_rdata_r    <= 20'h00000;
`ifdef MEM_ARB_RR_EN
      last_grant_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.f_req || bus.d_req) begin
            addr_r       <= sel_addr_s;
            we_r         <= pick_data_s & bus.d_we;
            wdata_r      <= pick_data_s ? bus.d_wdata : 8'h00;
            grant_r      <= pick_data_s;
            range_err_r  <= sel_err_s;
`ifdef MEM_ARB_RR_EN
            last_grant_r <= pick_data_s;
`endif
            state_r      <= ACCESS;
          end else begin
            state_r      <= IDLE;
          end
        end
        ACCESS: begin
          // Out-of-range accesses return zero rather than whatever the memory drives.
          if (grant_r) begin
            d_rdata_r <= range_err_r ? 20'h00000 : bus.mem_out;
          end else begin
            f_rdata_r <= range_err_r ? 20'h00000 : bus.mem_out;
          end
          state_r <= DONE;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Acks decode the state register so they still appear if reset lands in DONE.
  assign bus.f_ack    = (state_r == DONE) & ~grant_r;
  assign bus.d_ack    = (state_r == DONE) & grant_r;
  assign bus.d_err    = (state_r == DONE) & grant_r & range_err_r;
  assign bus.f_rdata  = f_rdata_r;
  assign bus.d_rdata  = d_rdata_r;
  assign bus.mem_addr = addr_r;
  assign bus.mem_in   = wdata_r;
  assign bus.mem_w    = (state_r == ACCESS) & we_r & ~range_err_r & ~rst;
  assign bus.busy     = (state_r == ACCESS) | (state_r == DONE);
  assign bus.grant    = grant_r;

endmodule
